// File: rtl/pwm_reg_arbiter.sv
// Arbitrated 4x8 PWM configuration bank. SPI and host writes share a shadow bank;
// each committed write reloads the active bank atomically and pulses cfg_update.
module pwm_reg_arbiter #(
  parameter logic [31:0] REG_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  spi_addr,
  input  logic [7:0]  spi_wdata,
  input  logic        spi_wr_en,
  output logic [7:0]  spi_rd_data,
  input  logic        hs_req,
  input  logic        hs_we,
  input  logic [1:0]  hs_addr,
  input  logic [7:0]  hs_wdata,
  output logic        hs_gnt,
  output logic [7:0]  hs_rdata,
  output logic [31:0] regs_o,
  output logic        cfg_update,
  output logic        spi_ovr
);

  typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, RDWAIT = 2'd2} state_t;
  typedef enum logic {GNT_SPI = 1'b0, GNT_HOST = 1'b1} requester_t;

  state_t     state, state_nxt;
  requester_t last_gnt;

  logic       spi_we_q, spi_pend, spi_rise;
  logic [1:0] pend_addr;
  logic [7:0] pend_data;
  logic [7:0] shadow [4];

  logic       tie, spi_win, host_win;
  logic       shadow_we;
  logic [1:0] shadow_waddr;
  logic [7:0] shadow_wdata;

  // Level-held SPI enable becomes a single request on its rising edge.
  assign spi_rise = spi_wr_en & ~spi_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    state_nxt = state;
    tie       = 1'b0;
    spi_win   = 1'b0;
    host_win  = 1'b0;
    case (state)
      IDLE: begin
        tie = spi_pend & hs_req;
        if (tie) begin
          spi_win  = (last_gnt == GNT_HOST);
          host_win = (last_gnt == GNT_SPI);
        end else begin
          spi_win  = spi_pend;
          host_win = hs_req;
        end
        if (spi_win || (host_win && hs_we)) state_nxt = UPDATE;
        else if (host_win)                  state_nxt = RDWAIT;
      end
      UPDATE:  state_nxt = IDLE;
      RDWAIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shadow_we    = spi_win | (host_win & hs_we);
    shadow_waddr = spi_win ? pend_addr : hs_addr;
    shadow_wdata = spi_win ? pend_data : hs_wdata;
  end

  // A rise on the same edge the old entry commits is a clean hand-over, not an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_we_q  <= 1'b0;
      spi_pend  <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      spi_ovr   <= 1'b0;
    end else begin
      spi_we_q <= spi_wr_en;
      if (spi_rise) begin
        pend_addr <= spi_addr;
        pend_data <= spi_wdata;
        spi_pend  <= 1'b1;
        if (spi_pend && !spi_win) spi_ovr <= 1'b1;
      end else if (spi_win) begin
        spi_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the bank is four ordinary flops, so it is reset explicitly rather than treated as RAM.
      for (int i = 0; i < 4; i++) shadow[i] <= REG_RESET[8*i +: 8];
      regs_o <= REG_RESET;
    end else begin
      if (shadow_we) shadow[shadow_waddr] <= shadow_wdata;
      if (state == UPDATE) regs_o <= {shadow[3], shadow[2], shadow[1], shadow[0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt    <= GNT_HOST;
      hs_gnt      <= 1'b0;
      hs_rdata    <= '0;
      cfg_update  <= 1'b0;
      spi_rd_data <= REG_RESET[7:0];
    end else begin
      if (tie) last_gnt <= spi_win ? GNT_SPI : GNT_HOST;
      hs_gnt      <= host_win;
      if (host_win) hs_rdata <= shadow[hs_addr];
      cfg_update  <= (state == UPDATE);
      spi_rd_data <= shadow[spi_addr];
    end
  end

endmodule
